// File: rtl/data_mem_resp_if.sv
// Request/response bus between a load-store unit and data_mem_resp.
// master drives req/rw/size/unsigned/addr/wdata; slave returns ready/rdata/rvalid/ack/err.
interface data_mem_resp_if;
  logic        req_i;
  logic        ready_o;
  logic        mem_rw_i;
  logic [1:0]  mem_size_i;
  logic        mem_unsigned_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        rvalid_o;
  logic        ack_o;
  logic        err_o;

  modport master (
    output req_i,
    output mem_rw_i,
    output mem_size_i,
    output mem_unsigned_i,
    output addr_i,
    output wdata_i,
    input  ready_o,
    input  rdata_o,
    input  rvalid_o,
    input  ack_o,
    input  err_o
  );

  modport slave (
    input  req_i,
    input  mem_rw_i,
    input  mem_size_i,
    input  mem_unsigned_i,
    input  addr_i,
    input  wdata_i,
    output ready_o,
    output rdata_o,
    output rvalid_o,
    output ack_o,
    output err_o
  );
endinterface

// File: rtl/data_mem_resp.sv
// Word-organised data memory with byte/half/word access and fixed wait states.
// Ports: clk, rst (sync, active-low), bus (data_mem_resp_if.slave).
module data_mem_resp #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst,
  data_mem_resp_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_nxt;
  logic          r_rw;
  logic [1:0]    r_size;
  logic          r_uns;
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_ready;
  logic          w_accept;
  logic          w_resp;
  logic          w_err;
  logic          w_we;
  logic [3:0]    w_be;
  logic [31:0]   w_wdat;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_ld;
  logic          w_unused;

  // high address bits alias onto the same storage
  assign w_unused = &{1'b0, bus.addr_i[31:AW+2]};

  // outputs are gated by rst so reset and abort take effect at once
  assign w_ready  = rst & (r_state == S_IDLE);
  assign w_accept = w_ready & bus.req_i;
  assign w_resp   = rst & (r_state == S_RESP);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_cnt_nxt = 4'(WAIT_CYCLES);
          w_next    = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) w_next = S_RESP;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rw    <= bus.mem_rw_i;
      r_size  <= bus.mem_size_i;
      r_uns   <= bus.mem_unsigned_i;
      r_addr  <= bus.addr_i[AW+1:0];
      r_wdata <= bus.wdata_i;
    end
  end

  assign w_err = (r_size == 2'd3)
               | ((r_size == 2'd1) & r_addr[0])
               | ((r_size == 2'd2) & (r_addr[1:0] != 2'd0));

  assign w_idx = r_addr[AW+1:2];
  assign w_we  = w_resp & r_rw & ~w_err;

  always_comb begin
    w_be   = 4'b1111;
    w_wdat = r_wdata;
    unique case (1'b1)
      (r_size == 2'd0): begin
        w_be   = 4'b0001 << r_addr[1:0];
        w_wdat = {4{r_wdata[7:0]}};
      end
      (r_size == 2'd1): begin
        w_be   = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdat = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be   = 4'b1111;
        w_wdat = r_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdat[8*b +: 8];
      end
    end
  end

  assign w_word = r_mem[w_idx];
  assign w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_byte = w_word[7:0];
    unique case (r_addr[1:0])
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
  end

  always_comb begin
    w_ld = w_word;
    unique case (1'b1)
      (r_size == 2'd0): w_ld = {{24{~r_uns & w_byte[7]}}, w_byte};
      (r_size == 2'd1): w_ld = {{16{~r_uns & w_half[15]}}, w_half};
      default:          w_ld = w_word;
    endcase
  end

  assign bus.ready_o  = w_ready;
  assign bus.err_o    = w_resp & w_err;
  assign bus.ack_o    = w_resp & ~w_err & r_rw;
  assign bus.rvalid_o = w_resp & ~w_err & ~r_rw;
  assign bus.rdata_o  = bus.rvalid_o ? w_ld : 32'd0;

endmodule

// File: tb/tb_data_mem_resp.sv
// Randomised and directed checks of data_mem_resp against a byte-array model.
// Drives the interface on negedges, samples on negedges.
module tb_data_mem_resp;

  localparam int DEPTH = 64;
  localparam int W     = 2;
  localparam int NB    = DEPTH * 4;

  logic clk;
  logic rst;
  int   checks;
  int   fails;

  logic [7:0] mb [NB];

  data_mem_resp_if bus ();

  data_mem_resp #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_CYCLES (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, expv);
    end
  endtask

  function automatic logic mdl_err(logic [31:0] a, logic [1:0] sz);
    logic [31:0] n;
    n = 32'd1 << sz;
    return (sz == 2'd3) || ((a % n) != 32'd0);
  endfunction

  function automatic logic [31:0] mdl_ld(logic [31:0] a, logic [1:0] sz,
                                         logic us);
    int          n;
    int          base;
    logic [31:0] v;
    n    = 1 << sz;
    base = int'(a % NB);
    v    = 32'd0;
    for (int k = 0; k < n; k++) v = v | (32'(mb[base+k]) << (8*k));
    if (n < 4 && !us && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic mdl_st(input logic [31:0] a, input logic [1:0] sz,
                        input logic [31:0] wd);
    int n;
    int base;
    n    = 1 << sz;
    base = int'(a % NB);
    for (int k = 0; k < n; k++) mb[base+k] = 8'(wd >> (8*k));
  endtask

  task automatic xact(input string tag, input logic rw, input logic [1:0] sz,
                      input logic us, input logic [31:0] a,
                      input logic [31:0] wd);
    int          lat;
    logic [2:0]  fl;
    logic [31:0] rd;
    logic        er;
    logic [2:0]  efl;
    logic [31:0] erd;
    er  = mdl_err(a, sz);
    efl = er ? 3'b001 : (rw ? 3'b010 : 3'b100);
    erd = (er || rw) ? 32'd0 : mdl_ld(a, sz, us);
    @(negedge clk);
    bus.req_i          = 1'b1;
    bus.mem_rw_i       = rw;
    bus.mem_size_i     = sz;
    bus.mem_unsigned_i = us;
    bus.addr_i         = a;
    bus.wdata_i        = wd;
    chk({tag, "_ready"}, 32'(bus.ready_o), 32'd1);
    lat = 0;
    fl  = 3'b000;
    rd  = 32'd0;
    for (int c = 1; c <= W + 8; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_i = 1'b0;
      if (bus.rvalid_o || bus.ack_o || bus.err_o) begin
        lat = c;
        fl  = {bus.rvalid_o, bus.ack_o, bus.err_o};
        rd  = bus.rdata_o;
        break;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'(W + 1));
    chk({tag, "_flags"}, 32'(fl), 32'(efl));
    chk({tag, "_rdata"}, rd, erd);
    if (rw && !er) mdl_st(a, sz, wd);
  endtask

  initial begin
    int          rec [16];
    int          nrec;
    int          npulse;
    logic [31:0] a;
    logic [1:0]  sz;
    logic [31:0] oldw;

    checks             = 0;
    fails              = 0;
    rst                = 1'b0;
    bus.req_i          = 1'b0;
    bus.mem_rw_i       = 1'b0;
    bus.mem_size_i     = 2'd0;
    bus.mem_unsigned_i = 1'b0;
    bus.addr_i         = 32'd0;
    bus.wdata_i        = 32'd0;

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.ready_o), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid_o), 32'd0);
    chk("rst_ack", 32'(bus.ack_o), 32'd0);
    chk("rst_err", 32'(bus.err_o), 32'd0);
    chk("rst_rdata", bus.rdata_o, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(bus.ready_o), 32'd1);

    // fill storage; random high bits exercise aliasing
    for (int i = 0; i < DEPTH; i++) begin
      a = ($urandom() & 32'hFFFF_FF00) | (32'(i) << 2);
      xact("init", 1'b1, 2'd2, 1'b0, a, $urandom());
    end

    xact("d36_st", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
    xact("d36_ld", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    chk("d36_mdl", mdl_ld(32'h10, 2'd2, 1'b0), 32'hDEAD_BEEF);

    xact("d37_clr", 1'b1, 2'd2, 1'b0, 32'h10, 32'h0);
    xact("d37_stb", 1'b1, 2'd0, 1'b0, 32'h13, 32'h80);
    xact("d37_lbs", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
    xact("d37_lbu", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    xact("d37_lw", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    chk("d37_mdl_s", mdl_ld(32'h13, 2'd0, 1'b0), 32'hFFFF_FF80);
    chk("d37_mdl_w", mdl_ld(32'h10, 2'd2, 1'b0), 32'h8000_0000);

    xact("d38_st", 1'b1, 2'd2, 1'b0, 32'h20, 32'hAAAA_AAAA);
    xact("d38_sth", 1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_1234);
    xact("d38_lw", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    chk("d38_mdl", mdl_ld(32'h20, 2'd2, 1'b0), 32'h1234_AAAA);

    xact("d39_stw", 1'b1, 2'd2, 1'b0, 32'h05, 32'h1111_1111);
    xact("d39_ldh", 1'b0, 2'd1, 1'b0, 32'h03, 32'h0);
    xact("d39_sz3", 1'b1, 2'd3, 1'b0, 32'h04, 32'h2222_2222);
    xact("d39_lw", 1'b0, 2'd2, 1'b0, 32'h04, 32'h0);

    for (int i = 0; i < 200; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom();
      if ($urandom_range(0, 3) != 0 && sz != 2'd3)
        a = a & ~((32'd1 << sz) - 32'd1);
      xact("rnd", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
           a, $urandom());
    end

    // req_i held high: one accept per W+2 cycles
    @(negedge clk);
    bus.req_i          = 1'b1;
    bus.mem_rw_i       = 1'b0;
    bus.mem_size_i     = 2'd2;
    bus.mem_unsigned_i = 1'b0;
    bus.addr_i         = 32'h10;
    nrec   = 0;
    npulse = 0;
    for (int c = 0; c < 4 * (W + 2) + 1; c++) begin
      if (c > 0) @(negedge clk);
      if (bus.ready_o && nrec < 16) begin
        rec[nrec] = c;
        nrec++;
      end
      if (bus.rvalid_o) begin
        npulse++;
        chk("b2b_rdy_resp", 32'(bus.ready_o), 32'd0);
        chk("b2b_rdata", bus.rdata_o, mdl_ld(32'h10, 2'd2, 1'b0));
      end
    end
    bus.req_i = 1'b0;
    chk("b2b_naccept", 32'(nrec), 32'd5);
    chk("b2b_npulse", 32'(npulse), 32'd4);
    for (int k = 1; k < nrec; k++)
      chk("b2b_gap", 32'(rec[k] - rec[k-1]), 32'(W + 2));
    repeat (W + 3) @(negedge clk);

    // reset during WAIT aborts the store
    oldw = mdl_ld(32'h40, 2'd2, 1'b0);
    bus.req_i      = 1'b1;
    bus.mem_rw_i   = 1'b1;
    bus.mem_size_i = 2'd2;
    bus.addr_i     = 32'h40;
    bus.wdata_i    = ~oldw;
    chk("abt_ready", 32'(bus.ready_o), 32'd1);
    @(negedge clk);
    bus.req_i = 1'b0;
    rst       = 1'b0;
    for (int c = 0; c < W + 2; c++) begin
      @(negedge clk);
      chk("abt_pulse", 32'({bus.rvalid_o, bus.ack_o, bus.err_o}), 32'd0);
      chk("abt_ready_lo", 32'(bus.ready_o), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abt_ready_hi", 32'(bus.ready_o), 32'd1);
    chk("abt_pulse2", 32'({bus.rvalid_o, bus.ack_o, bus.err_o}), 32'd0);
    xact("abt_lw", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    chk("abt_mdl", mdl_ld(32'h40, 2'd2, 1'b0), oldw);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
